// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate response checker.
package gate_chk_pkg;

  localparam int MAX_LATENCY = 7;
  localparam int MAX_WIDTH   = 64;

  typedef enum logic [1:0] {
    GATE_AND  = 2'd0,
    GATE_OR   = 2'd1,
    GATE_XOR  = 2'd2,
    GATE_NAND = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  // Bitwise reference gate; callers zero-extend inputs and truncate the result.
  function automatic logic [MAX_WIDTH-1:0] gate_eval(input gate_op_e op,
                                                     input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b);
    case (op)
      GATE_AND: gate_eval = a & b;
      GATE_OR:  gate_eval = a | b;
      GATE_XOR: gate_eval = a ^ b;
      default:  gate_eval = ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/gate_response_checker_delay.sv
// {valid, data} delay line matching the DUT latency. LATENCY=0 is a
// pass-through. clr drops everything in flight but still loads the entry
// presented in the same cycle, so a restart can carry its first stimulus.
module gate_chk_delay #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  if (LATENCY == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, clr};
    assign out_vld    = in_vld;
    assign out_dat    = in_dat;
  end else begin : g_pipe
    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][WIDTH-1:0] dat_q, dat_d;

    // Shift one stage per cycle; older entries are invalidated on clr.
    always_comb begin
      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = in_vld;
      dat_d[0] = in_dat;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1] & ~clr;
        dat_d[i] = dat_q[i-1];
      end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_dat = dat_q[LATENCY-1];
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for two-input bitwise gate DUTs: computes the expected
// output of each accepted stimulus, aligns it to the DUT latency, compares,
// and keeps saturating check/error tallies plus the first mismatch.
// Optional build macro GATE_CHK_STOP_ON_ERR_EN: the first mismatch ends the
// run (next state DONE, pending expectations discarded).
module gate_response_checker #(
  parameter int WIDTH   = 1,
  parameter int OP      = 0,
  parameter int LATENCY = 0,   // 0..MAX_LATENCY
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             end_i,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic [WIDTH-1:0] dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);
  import gate_chk_pkg::*;

  localparam gate_op_e         OP_E       = gate_op_e'(2'(OP));
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]       DRAIN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  chk_state_e       state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic [CNT_W-1:0] chk_q, chk_d, err_q, err_d, fidx_q, fidx_d;
  logic [WIDTH-1:0] fexp_q, fexp_d, fgot_q, fgot_d;

  logic             accept, stop_hit, cmp_en, cmp_mis;
  logic             dly_vld;
  logic [WIDTH-1:0] exp_now, dly_dat;

  // A start cycle counts as the first RUN cycle, so its stimulus is check 0.
  assign accept  = stim_valid & (start | (state_q == ST_RUN));
  assign exp_now = WIDTH'(gate_eval(OP_E, MAX_WIDTH'(stim_a), MAX_WIDTH'(stim_b)));

  // Entries still in flight at a restart belong to the old run: never compare them.
  assign cmp_en  = dly_vld & ((LATENCY == 0) | ~start);
  assign cmp_mis = cmp_en & (dly_dat != dut_c);

`ifdef GATE_CHK_STOP_ON_ERR_EN
  assign stop_hit = cmp_mis;
`else
  assign stop_hit = 1'b0;
`endif

  gate_chk_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (start | stop_hit),
    .in_vld  (accept & ~(stop_hit & ~start)),
    .in_dat  (exp_now),
    .out_vld (dly_vld),
    .out_dat (dly_dat)
  );

  // Next state: drain for exactly LATENCY cycles after end_i; start restarts; a stop ends the run.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (end_i) begin
          if (LATENCY == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LAST;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == 3'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      default: ;
    endcase
    if (start)    state_d = ST_RUN;
    if (stop_hit) state_d = ST_DONE;
  end

  // Tallies: restart clears first, then the current comparison is applied on top.
  always_comb begin
    chk_d  = start ? '0 : chk_q;
    err_d  = start ? '0 : err_q;
    fidx_d = start ? '0 : fidx_q;
    fexp_d = start ? '0 : fexp_q;
    fgot_d = start ? '0 : fgot_q;
    if (cmp_en) begin
      if (cmp_mis && (err_d == '0)) begin
        fidx_d = chk_d;
        fexp_d = dly_dat;
        fgot_d = dut_c;
      end
      if (cmp_mis && (err_d != CNT_MAX)) err_d = err_d + CNT_W'(1);
      if (chk_d != CNT_MAX)              chk_d = chk_d + CNT_W'(1);
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
    pass = done && (chk_q != '0) && (err_q == '0);
  end

  assign chk_cnt       = chk_q;
  assign err_cnt       = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (4-bit NAND, latency 2,
// 4-bit counters; 1-bit AND, latency 0, 16-bit counters) share randomized
// run plans. Results are predicted per run from the plan alone.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, end_i, stim_valid;
  logic [3:0] stim_a, stim_b, dut_c0;
  logic       dut_c1;

  logic        busy0, done0, pass0;
  logic [3:0]  chk0, err0, fidx0, fexp0, fgot0;
  logic        busy1, done1, pass1;
  logic [15:0] chk1, err1, fidx1;
  logic        fexp1, fgot1;

  gate_response_checker #(.WIDTH(4), .OP(3), .LATENCY(2), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .end_i(end_i), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_c(dut_c0),
    .busy(busy0), .done(done0), .pass(pass0), .chk_cnt(chk0), .err_cnt(err0),
    .first_err_idx(fidx0), .first_err_exp(fexp0), .first_err_got(fgot0));

  gate_response_checker #(.WIDTH(1), .OP(0), .LATENCY(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .end_i(end_i), .stim_valid(stim_valid),
    .stim_a(stim_a[0]), .stim_b(stim_b[0]), .dut_c(dut_c1),
    .busy(busy1), .done(done1), .pass(pass1), .chk_cnt(chk1), .err_cnt(err1),
    .first_err_idx(fidx1), .first_err_exp(fexp1), .first_err_got(fgot1));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int s_cyc = 0;
  bit run_active = 1'b0;
  int d[2], e_chk[2], e_err[2], e_fidx[2], e_fexp[2], e_fgot[2];
  int p_vld[64], p_end[64], p_a[64], p_b[64], p_m0[64], p_m1[64];
  logic [3:0] sched0[int];
  logic       sched1[int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive after the edge, check at the falling edge.
  task automatic tick(input logic st, input logic en, input logic sv,
                      input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    cyc++;
    #1;
    start = st; end_i = en; stim_valid = sv; stim_a = a; stim_b = b;
    dut_c0 = sched0.exists(cyc) ? sched0[cyc] : 4'($urandom);
    dut_c1 = sched1.exists(cyc) ? sched1[cyc] : 1'($urandom);
    @(negedge clk);
    if (run_active && cyc > s_cyc) begin
      chk("busy0", busy0, cyc < d[0]);
      chk("done0", done0, cyc >= d[0]);
      chk("busy1", busy1, cyc < d[1]);
      chk("done1", done1, cyc >= d[1]);
      if (cyc == d[0]) begin
        chk("chk_cnt0", chk0, e_chk[0]);
        chk("err_cnt0", err0, e_err[0]);
        chk("pass0", pass0, (e_chk[0] != 0) && (e_err[0] == 0));
        chk("first_idx0", fidx0, e_fidx[0]);
        chk("first_exp0", fexp0, e_fexp[0]);
        chk("first_got0", fgot0, e_fgot[0]);
      end
      if (cyc == d[1]) begin
        chk("chk_cnt1", chk1, e_chk[1]);
        chk("err_cnt1", err1, e_err[1]);
        chk("pass1", pass1, (e_chk[1] != 0) && (e_err[1] == 0));
        chk("first_idx1", fidx1, e_fidx[1]);
        chk("first_exp1", fexp1, e_fexp[1]);
        chk("first_got1", fgot1, e_fgot[1]);
      end
    end
  endtask

  task automatic check_zero();
    chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0); chk("rst_pass0", pass0, 0);
    chk("rst_chk0", chk0, 0);   chk("rst_err0", err0, 0);   chk("rst_idx0", fidx0, 0);
    chk("rst_exp0", fexp0, 0);  chk("rst_got0", fgot0, 0);
    chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0); chk("rst_pass1", pass1, 0);
    chk("rst_chk1", chk1, 0);   chk("rst_err1", err1, 0);   chk("rst_idx1", fidx1, 0);
    chk("rst_exp1", fexp1, 0);  chk("rst_got1", fgot1, 0);
  endtask

  task automatic do_reset();
    run_active = 1'b0;
    rst = 1'b1;
    repeat (2) tick(0, 0, 0, 4'($urandom), 4'($urandom));
    check_zero();
    rst = 1'b0;
  endtask

  // Predict one instance's outcome from the plan: checks happen in order,
  // LAT cycles after acceptance; counters saturate at MAXC.
  task automatic model(input int inst, input int len, input int s);
    int lat, maxc, n, errs, fi, fe, fg, dc;
    lat  = inst ? 0 : 2;
    maxc = inst ? 65535 : 15;
    n = 0; errs = 0; fi = -1; fe = 0; fg = 0;
    dc = s + (len - 1) + lat + 1;
    for (int j = 0; j < len; j++) begin
      if (p_vld[j] != 0) begin
        int e, m;
        e = inst ? (p_a[j] & p_b[j] & 1) : (~(p_a[j] & p_b[j]) & 15);
        m = inst ? p_m1[j] : p_m0[j];
        if (m != 0) begin
          if (fi < 0) begin
            fi = n; fe = e; fg = e ^ m;
          end
          errs++;
        end
        n++;
`ifdef GATE_CHK_STOP_ON_ERR_EN
        if (m != 0) begin
          dc = s + j + lat + 1;
          break;
        end
`endif
      end
    end
    d[inst]      = dc;
    e_chk[inst]  = (n < maxc) ? n : maxc;
    e_err[inst]  = (errs < maxc) ? errs : maxc;
    e_fidx[inst] = (fi < 0) ? 0 : ((fi < maxc) ? fi : maxc);
    e_fexp[inst] = (fi < 0) ? 0 : fe;
    e_fgot[inst] = (fi < 0) ? 0 : fg;
  endtask

  // One run: start at offset 0 (optionally with a stimulus), random gaps,
  // end_i with the final vector. An aborted run stops without end_i and is
  // left busy for the caller to restart or reset.
  task automatic run(input int len, input int vpct, input int epct, input bit v0, input bit abort);
    int s, last;
    s = cyc + 1;
    for (int j = 0; j < len; j++) begin
      if (j == 0)                   p_vld[j] = v0;
      else if (j == len-1 && !abort) p_vld[j] = 1;
      else                          p_vld[j] = ($urandom_range(99) < vpct) ? 1 : 0;
      p_end[j] = (j == len-1 && !abort) ? 1 : 0;
      p_a[j]   = $urandom_range(15);
      p_b[j]   = $urandom_range(15);
      p_m0[j]  = ($urandom_range(99) < epct) ? $urandom_range(15, 1) : 0;
      p_m1[j]  = ($urandom_range(99) < epct) ? 1 : 0;
      if (p_vld[j] != 0) begin
        sched0[s+j+2] = 4'((~(p_a[j] & p_b[j])) ^ p_m0[j]);
        sched1[s+j]   = 1'((p_a[j] & p_b[j] & 1) ^ p_m1[j]);
      end
    end
    if (abort) begin
      d[0] = 1 << 30;
      d[1] = 1 << 30;
    end else begin
      model(0, len, s);
      model(1, len, s);
    end
    s_cyc = s;
    run_active = 1'b1;
    for (int j = 0; j < len; j++)
      tick(j == 0, 1'(p_end[j]), 1'(p_vld[j]), 4'(p_a[j]), 4'(p_b[j]));
    if (!abort) begin
      last = (d[0] > d[1]) ? d[0] : d[1];
      // Idle tail with stray end_i/stim_valid that must be ignored.
      while (cyc < last + 2)
        tick(0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; end_i = 1'b0; stim_valid = 1'b0;
    stim_a = '0; stim_b = '0; dut_c0 = '0; dut_c1 = 1'b0;
    do_reset();
    run(6, 100, 0, 0, 0);      // clean, back-to-back
    run(10, 70, 30, 0, 0);     // gaps and some mismatches
    run(24, 100, 15, 0, 0);    // narrow counters saturate on checks
    run(24, 100, 90, 0, 0);    // and on errors
    run(5, 100, 0, 0, 1);      // abandoned mid-run ...
    run(10, 80, 20, 1, 0);     // ... restarted with a stimulus in the start cycle
    run(4, 100, 0, 0, 1);      // abandoned, then reset
    do_reset();
    run(6, 100, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      run($urandom_range(20, 3), $urandom_range(100, 50), $urandom_range(40), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
